// File: rtl/pool_stride_layer.sv
// Streaming KxK max/average pooling with configurable stride over a raster-order image.
// All channels are pooled in parallel; one result per valid window position.
module pool_stride_layer #(
    parameter int DATA_SIZE       = 8,
    parameter int INPUT_CHANNELS  = 256,
    parameter int IMG_DIM         = 13,
    parameter int KERNEL_DIM      = 3,
    parameter int STRIDE          = 2,
    parameter int POOL_MODE       = 0,
    parameter int OUTPUT_CHANNELS = INPUT_CHANNELS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic                                 i_ibuf_we,
    input  logic [DATA_SIZE*INPUT_CHANNELS-1:0]  i_ibuf_wr_data,
    output logic                                 o_ready,
    input  logic                                 i_next_ready,
    output logic [DATA_SIZE*OUTPUT_CHANNELS-1:0] o_next_data,
    output logic                                 o_next_we,
    output logic                                 o_next_start,
    output logic                                 o_done
);
    localparam int FIFO_LENGTH = IMG_DIM * (KERNEL_DIM - 1) + KERNEL_DIM;
    localparam int PIX_W       = DATA_SIZE * INPUT_CHANNELS;
    localparam int OUT_W       = DATA_SIZE * OUTPUT_CHANNELS;
    localparam int POS_W       = $clog2(IMG_DIM + 1);
    localparam int PH_W        = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WIN         = KERNEL_DIM * KERNEL_DIM;
    localparam int SUM_W       = DATA_SIZE + $clog2(WIN);

    // IDLE: wait for start | RUN: accept pixels | FLUSH: last output drains, done follows
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_DIM - 1);
    localparam logic [POS_W-1:0] KM1      = POS_W'(KERNEL_DIM - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(STRIDE - 1);

    logic [1:0]           state_q, state_d;
    logic [POS_W-1:0]     col_q, col_d, row_q, row_d, col_nx, row_nx;
    logic [PH_W-1:0]      col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic [PIX_W-1:0]     fifo_q  [FIFO_LENGTH];
    logic [PIX_W-1:0]     fifo_d  [FIFO_LENGTH];
    logic [PIX_W-1:0]     fifo_sh [FIFO_LENGTH];
    logic [OUT_W-1:0]     data_q, data_d, pool_res;
    logic                 we_q, we_d, start_q, start_d, done_q, done_d;
    logic                 accept, win_valid, last_pix;
    logic [DATA_SIZE-1:0] px, mx;
    logic [SUM_W-1:0]     sum;

    assign o_ready   = (state_q == S_RUN) && i_next_ready;
    assign accept    = i_ibuf_we && o_ready;
    assign win_valid = (row_q >= KM1) && (col_q >= KM1) && (row_ph_q == '0) && (col_ph_q == '0);
    assign last_pix  = (row_q == LAST_POS) && (col_q == LAST_POS);

    // Window is taken from the line buffer as it looks after the incoming pixel shifts in
    always_comb begin
        fifo_sh[0] = i_ibuf_wr_data;
        for (int i = 1; i < FIFO_LENGTH; i++) begin
            fifo_sh[i] = fifo_q[i-1];
        end
    end

    always_comb begin
        pool_res = '0;
        px       = '0;
        mx       = '0;
        sum      = '0;
        for (int ch = 0; ch < OUTPUT_CHANNELS; ch++) begin
            mx  = '0;
            sum = '0;
            for (int r = 0; r < KERNEL_DIM; r++) begin
                for (int c = 0; c < KERNEL_DIM; c++) begin
                    px = fifo_sh[(KERNEL_DIM-1-r)*IMG_DIM + (KERNEL_DIM-1-c)][ch*DATA_SIZE +: DATA_SIZE];
                    if (px > mx) mx = px;
                    sum = sum + SUM_W'(px);
                end
            end
            pool_res[ch*DATA_SIZE +: DATA_SIZE] = (POOL_MODE == 1) ? DATA_SIZE'(sum / SUM_W'(WIN)) : mx;
        end
    end

    always_comb begin
        if (col_q == LAST_POS) begin
            col_nx = '0;
            row_nx = row_q + POS_W'(1);
        end else begin
            col_nx = col_q + POS_W'(1);
            row_nx = row_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        fifo_d   = fifo_q;
        data_d   = data_q;
        we_d     = 1'b0;
        start_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_RUN;
                    start_d  = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    col_ph_d = '0;
                    row_ph_d = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    fifo_d = fifo_sh;
                    col_d  = col_nx;
                    row_d  = row_nx;
                    // phases are only meaningful once the window fits, so realign at K-1
                    col_ph_d = ((col_nx == KM1) || (col_ph_q == PH_LAST)) ? '0 : col_ph_q + PH_W'(1);
                    if (col_q == LAST_POS) begin
                        row_ph_d = ((row_nx == KM1) || (row_ph_q == PH_LAST)) ? '0 : row_ph_q + PH_W'(1);
                    end
                    if (win_valid) begin
                        we_d   = 1'b1;
                        data_d = pool_res;
                    end
                    if (last_pix) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
            for (int i = 0; i < FIFO_LENGTH; i++) fifo_q[i] <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            col_ph_q <= col_ph_d;
            row_ph_q <= row_ph_d;
            fifo_q   <= fifo_d;
            data_q   <= data_d;
            we_q     <= we_d;
            start_q  <= start_d;
            done_q   <= done_d;
        end
    end

    assign o_next_data  = data_q;
    assign o_next_we    = we_q;
    assign o_next_start = start_q;
    assign o_done       = done_q;

endmodule
